karatsuba_mult: RTL and testbench
=================================

KARATSUBA_MULT -- requirements
Module: karatsuba_mult

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width in bits; N SHALL be even and at least 4, and H = N/2.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The block SHALL have the port start, input, 1 bit, the request to multiply X by Y; it is sampled only while ready=1.
REQ-005 The block SHALL have the port X, input, N bits, the unsigned multiplicand.
REQ-006 The block SHALL have the port Y, input, N bits, the unsigned multiplier.
REQ-007 The block SHALL have the port ready, output, 1 bit, high exactly when the FSM is in IDLE.
REQ-008 The block SHALL have the port done, output, 1 bit, a one-cycle pulse marking a new valid R.
REQ-009 The block SHALL have the port R, output, 2N bits, the registered product X*Y.

Function
REQ-010 Arithmetic SHALL follow Karatsuba with XH/XL and YH/YL as the upper/lower H bits: Z0=XL*YL, Z2=XH*YH, SX=XH+XL, SY=YH+YL (H+1 bits each), Z1=SX*SY-Z2-Z0, R=Z2*2^N+Z1*2^H+Z0.
REQ-011 The datapath SHALL contain exactly one (H+1)x(H+1) unsigned multiplier (N+2-bit product) and one 2N-bit adder/subtractor, both shared across states through muxes; no other multipliers.
REQ-012 Internal registers SHALL be: XR/YR (N), Z0 (N), Z2 (N), SX/SY (H+1), P (N+2), T (N+1), Z1 (N+1), and RR (2N) driving R.
REQ-013 FSM states SHALL be IDLE, S0, S1, S2, S3, S4, DONE, each lasting exactly one cycle except IDLE.
REQ-014 IDLE: if start=1, load XR<=X and YR<=Y and go to S0; otherwise stay in IDLE.
REQ-015 S0: Z0<=XL*YL and SX<=XH+XL; S1: Z2<=XH*YH and SY<=YH+YL.
REQ-016 S2: P<=SX*SY and T<=Z2+Z0; S3: Z1<=P-T, which can never go negative because Z1=XH*YL+XL*YH < 2^(N+1).
REQ-017 S4: RR<={Z2,Z0}+(Z1<<H), truncated to 2N bits with no overflow possible.
REQ-018 DONE: done=1 for that cycle only, then the FSM returns to IDLE unconditionally.
REQ-019 Latency: with start=1 sampled in IDLE cycle c, done=1 in cycle c+6, and R is valid from cycle c+6.
REQ-020 R SHALL hold its value until the next S4 write; it is not cleared when a new operation starts.
REQ-021 start while ready=0 (S0..DONE) SHALL be ignored, with no queuing and no effect on XR, YR or the result; X and Y are don't-care outside the accept cycle.
REQ-022 With start held high continuously, a new operation SHALL be accepted every 7 cycles, on each IDLE cycle.
REQ-023 Operand edge values (0, all-ones, H-bit carry into SX/SY) SHALL produce exact results.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, ready=1, done=0, R=0 and all internal registers to 0, regardless of the clock.
REQ-025 Reset during any of S0..DONE SHALL abort the operation with no done pulse; after release the block behaves as freshly reset.
REQ-026 The first rising edge of clk with rst=1 SHALL be able to accept start.

Verification
REQ-027 N=8, X=0xFF, Y=0xFF, start pulsed in cycle 0 -> ready=0 in cycles 1-5, done=1 in cycle 6 only, R=0xFE01.
REQ-028 N=8, X=0xA7, Y=0x3C -> R=0x2724 at done; X=0x00, Y=0xB5 -> R=0x0000 at done.
REQ-029 N=8, start=1 again in cycle 3 with X=0x01, Y=0x01 during the 0xFF*0xFF operation -> ignored, R=0xFE01, a single done pulse.
REQ-030 N=8, start held high with fixed X=0x12, Y=0x34 -> done pulses in cycles 6, 13, 20, and R=0x03A8 each time.
REQ-031 rst=0 asserted in cycle 3 of an operation -> R=0, ready=1 asynchronously, and no done pulse follows.
REQ-032 N=16, X=0xFFFF, Y=0xFFFF -> R=0xFFFE0001; N=16, X=0x8001, Y=0x8001 -> R=0x40010001.

Source files
------------

// File: rtl/karatsuba_mult.sv
// Multi-cycle unsigned N x N Karatsuba multiplier.
// A single (H+1)x(H+1) multiplier and a single 2N-bit adder/subtractor are
// time-shared across the S0..S4 states.
module karatsuba_mult #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] R
);

  localparam int unsigned H  = N / 2;
  localparam int unsigned MW = H + 1;
  localparam int unsigned PW = N + 2;
  localparam int unsigned TW = N + 1;
  localparam int unsigned W2 = 2 * N;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    S4   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   xr_q, xr_d, yr_q, yr_d;
  logic [N-1:0]   z0_q, z0_d, z2_q, z2_d;
  logic [MW-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic [PW-1:0]  p_q, p_d;
  logic [TW-1:0]  t_q, t_d, z1_q, z1_d;
  logic [W2-1:0]  rr_q, rr_d;
  logic           ready_q, ready_d, done_q, done_d;

  logic [H-1:0]   xh, xl, yh, yl;
  logic [MW-1:0]  mul_a, mul_b;
  logic [PW-1:0]  mul_p;
  logic [W2-1:0]  add_a, add_b, add_s;
  logic           add_sub;

  assign xh = xr_q[N-1:H];
  assign xl = xr_q[H-1:0];
  assign yh = yr_q[N-1:H];
  assign yl = yr_q[H-1:0];

  // Shared arithmetic units.
  assign mul_p = PW'(mul_a) * PW'(mul_b);
  assign add_s = add_sub ? (add_a - add_b) : (add_a + add_b);

  // Operand muxes for the shared multiplier and adder/subtractor.
  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state_q)
      S0: begin
        mul_a = MW'(xl);
        mul_b = MW'(yl);
        add_a = W2'(xh);
        add_b = W2'(xl);
      end
      S1: begin
        mul_a = MW'(xh);
        mul_b = MW'(yh);
        add_a = W2'(yh);
        add_b = W2'(yl);
      end
      S2: begin
        mul_a = sx_q;
        mul_b = sy_q;
        add_a = W2'(z2_q);
        add_b = W2'(z0_q);
      end
      S3: begin
        add_a   = W2'(p_q);
        add_b   = W2'(t_q);
        add_sub = 1'b1;
      end
      S4: begin
        add_a = {z2_q, z0_q};
        add_b = W2'(z1_q) << H;
      end
      default: ;
    endcase
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    z0_d    = z0_q;
    z2_d    = z2_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    p_d     = p_q;
    t_d     = t_q;
    z1_d    = z1_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          xr_d    = X;
          yr_d    = Y;
          state_d = S0;
        end
      end
      S0: begin
        z0_d    = N'(mul_p);
        sx_d    = MW'(add_s);
        state_d = S1;
      end
      S1: begin
        z2_d    = N'(mul_p);
        sy_d    = MW'(add_s);
        state_d = S2;
      end
      S2: begin
        p_d     = mul_p;
        t_d     = TW'(add_s);
        state_d = S3;
      end
      S3: begin
        z1_d    = TW'(add_s);
        state_d = S4;
      end
      S4: begin
        rr_d    = add_s;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      p_q     <= '0;
      t_q     <= '0;
      z1_q    <= '0;
      rr_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      p_q     <= p_d;
      t_q     <= t_d;
      z1_q    <= z1_d;
      rr_q    <= rr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign R     = rr_q;

endmodule

// File: tb/tb_karatsuba_mult.sv
// Directed bench for karatsuba_mult at N=8 and N=16.
module tb_karatsuba_mult;

  logic        clk;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  x8, y8;
  logic [15:0] x16, y16;
  logic        ready8, done8, ready16, done16;
  logic [15:0] r8;
  logic [31:0] r16;

  int tests;
  int fails;

  karatsuba_mult #(.N(8)) u_mult8 (
    .clk(clk), .rst(rst), .start(start8), .X(x8), .Y(y8),
    .ready(ready8), .done(done8), .R(r8)
  );

  karatsuba_mult #(.N(16)) u_mult16 (
    .clk(clk), .rst(rst), .start(start16), .X(x16), .Y(y16),
    .ready(ready16), .done(done16), .R(r16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run one N=8 operation starting in the current IDLE cycle.
  task automatic run8(input logic [7:0] xa, input logic [7:0] ya,
                      input logic [15:0] exp, input logic [15:0] prev, input string tag);
    start8 = 1'b1; x8 = xa; y8 = ya;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) begin
        start8 = 1'b0; x8 = ~xa; y8 = 8'h5A;
        chk({tag, "_rhold"}, 64'(r8), 64'(prev));
      end
      if (k <= 5) chk({tag, "_busy"}, {62'd0, ready8, done8}, 64'd0);
    end
    chk({tag, "_done"}, 64'(done8), 64'd1);
    chk({tag, "_r"}, 64'(r8), 64'(exp));
    cyc();
    chk({tag, "_idle"}, {62'd0, ready8, done8}, 64'd2);
  endtask

  // Run one N=16 operation starting in the current IDLE cycle.
  task automatic run16(input logic [15:0] xa, input logic [15:0] ya,
                       input logic [31:0] exp, input string tag);
    start16 = 1'b1; x16 = xa; y16 = ya;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) begin start16 = 1'b0; x16 = 16'h0; y16 = 16'h0; end
    end
    chk({tag, "_done"}, 64'(done16), 64'd1);
    chk({tag, "_r"}, 64'(r16), 64'(exp));
    cyc();
    chk({tag, "_idle"}, {62'd0, ready16, done16}, 64'd2);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
    x8 = '0; y8 = '0; x16 = '0; y16 = '0;
    #12;
    chk("rst_ready8", 64'(ready8), 64'd1);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_r8", 64'(r8), 64'd0);
    chk("rst_ready16", 64'(ready16), 64'd1);

    // Release reset and request 0xFF*0xFF before the very first active edge.
    rst = 1'b1; start8 = 1'b1; x8 = 8'hFF; y8 = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) begin start8 = 1'b0; x8 = 8'h00; y8 = 8'h00; end
      if (k == 3) begin start8 = 1'b1; x8 = 8'h01; y8 = 8'h01; end
      if (k == 4) start8 = 1'b0;
      if (k <= 5) chk("ff_busy", {62'd0, ready8, done8}, 64'd0);
    end
    chk("ff_done", 64'(done8), 64'd1);
    chk("ff_ready_done", 64'(ready8), 64'd0);
    chk("ff_r", 64'(r8), 64'h FE01);
    for (int k = 7; k <= 13; k++) begin
      cyc();
      chk("ff_single_done", 64'(done8), 64'd0);
    end
    chk("ff_r_hold", 64'(r8), 64'hFE01);

    run8(8'hA7, 8'h3C, 16'h2724, 16'hFE01, "a7x3c");
    run8(8'h00, 8'hB5, 16'h0000, 16'h2724, "zero");
    run8(8'hFF, 8'h01, 16'h00FF, 16'h0000, "ffx01");
    run8(8'h0F, 8'h0F, 16'h00E1, 16'h00FF, "carry_lo");

    // Back-to-back operations with start held high.
    start8 = 1'b1; x8 = 8'h12; y8 = 8'h34;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 6 || k == 13 || k == 20) begin
        chk("held_done", 64'(done8), 64'd1);
        chk("held_r", 64'(r8), 64'h03A8);
      end else begin
        chk("held_nodone", 64'(done8), 64'd0);
      end
    end
    start8 = 1'b0;
    cyc();
    chk("held_idle", 64'(ready8), 64'd1);

    // Asynchronous reset in the middle of an operation.
    start8 = 1'b1; x8 = 8'hA7; y8 = 8'h3C;
    cyc();
    start8 = 1'b0;
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_r", 64'(r8), 64'd0);
    chk("arst_ready", 64'(ready8), 64'd1);
    chk("arst_done", 64'(done8), 64'd0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("arst_nodone", {62'd0, ready8, done8}, 64'd2);
    end
    chk("arst_r_after", 64'(r8), 64'd0);
    run8(8'h12, 8'h34, 16'h03A8, 16'h0000, "post_rst");

    // N=16 instance.
    run16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_ff");
    run16(16'h8001, 16'h8001, 32'h40010001, "w16_8001");
    run16(16'h00FF, 16'h0100, 32'h0000FF00, "w16_shift");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
